// File: rtl/click_key_array.sv
// click_key_array: N-channel push-button front end.
// Each channel has a 2-FF synchroniser, a stability debouncer and a
// short/long press classifier that emits one-cycle click strobes.
// Optional feature: define CLICK_KEY_REPEAT_EN to make long_click auto-repeat
// every REPEAT_MS while the key stays held past LONG_MS.
module click_key_array #(
    parameter int N_KEYS         = 4,
    parameter int IN_C_HZ        = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 500,
    parameter int REPEAT_MS      = 100,
    parameter bit KEY_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] in_key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] fast_click,
    output logic [N_KEYS-1:0] long_click
);
    localparam int CYC_PER_MS = IN_C_HZ / 1000;
    localparam int DEB_CNT    = DEBOUNCE_MS * CYC_PER_MS;
    localparam int LONG_CNT   = LONG_MS * CYC_PER_MS;
    localparam int REP_CNT    = REPEAT_MS * CYC_PER_MS;
    localparam int DEB_W      = $clog2(DEB_CNT + 1);
    localparam int HOLD_W     = $clog2(LONG_CNT + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
`ifdef CLICK_KEY_REPEAT_EN
    localparam int REP_W = $clog2(REP_CNT + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CNT - 1);
`endif

    generate
        if (DEB_CNT < 1 || LONG_CNT < 1 || REP_CNT < 1) begin : g_bad_cfg
            $error("click_key_array: derived DEB/LONG/REP counts must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;

    // Two-flop synchroniser; polarity is normalised so 1 always means pressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_key ^ {N_KEYS{KEY_ACTIVE_LOW}};
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            logic              r_ks;
            logic [DEB_W-1:0]  r_deb_cnt;
            state_t            r_state;
            state_t            w_state_nxt;
            logic [HOLD_W-1:0] r_hold_cnt;
            logic [HOLD_W-1:0] w_hold_nxt;
            logic              r_fast;
            logic              r_long;
            logic              w_fast_nxt;
            logic              w_long_nxt;
`ifdef CLICK_KEY_REPEAT_EN
            logic [REP_W-1:0]  r_rep_cnt;
            logic [REP_W-1:0]  w_rep_nxt;
`endif

            // Debouncer: the level only follows the synchronised key after it
            // has differed for DEB_CNT consecutive cycles.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ks      <= 1'b0;
                    r_deb_cnt <= '0;
                end else if (r_sync2[gi] == r_ks) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    r_ks      <= r_sync2[gi];
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end

            // Classifier next-state logic; release takes priority over the
            // long threshold so a press never yields both strobes.
            always_comb begin
                w_state_nxt = r_state;
                w_hold_nxt  = r_hold_cnt;
                w_fast_nxt  = 1'b0;
                w_long_nxt  = 1'b0;
`ifdef CLICK_KEY_REPEAT_EN
                w_rep_nxt   = r_rep_cnt;
`endif
                case (r_state)
                    ST_IDLE: begin
                        if (r_ks) begin
                            w_state_nxt = ST_PRESSED;
                            w_hold_nxt  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!r_ks) begin
                            w_fast_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_hold_nxt  = '0;
                        end else if (r_hold_cnt == HOLD_LAST) begin
                            w_long_nxt  = 1'b1;
                            w_state_nxt = ST_LONG;
                            w_hold_nxt  = '0;
`ifdef CLICK_KEY_REPEAT_EN
                            w_rep_nxt   = '0;
`endif
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    ST_LONG: begin
`ifdef CLICK_KEY_REPEAT_EN
                        if (!r_ks) begin
                            w_state_nxt = ST_IDLE;
                            w_rep_nxt   = '0;
                        end else if (r_rep_cnt == REP_LAST) begin
                            w_long_nxt = 1'b1;
                            w_rep_nxt  = '0;
                        end else begin
                            w_rep_nxt = r_rep_cnt + 1'b1;
                        end
`else
                        if (!r_ks) begin
                            w_state_nxt = ST_IDLE;
                        end
`endif
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end
                endcase
            end

            // Classifier state and registered strobes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                    r_fast     <= 1'b0;
                    r_long     <= 1'b0;
`ifdef CLICK_KEY_REPEAT_EN
                    r_rep_cnt  <= '0;
`endif
                end else begin
                    r_state    <= w_state_nxt;
                    r_hold_cnt <= w_hold_nxt;
                    r_fast     <= w_fast_nxt;
                    r_long     <= w_long_nxt;
`ifdef CLICK_KEY_REPEAT_EN
                    r_rep_cnt  <= w_rep_nxt;
`endif
                end
            end

            assign key_state[gi]  = r_ks;
            assign fast_click[gi] = r_fast;
            assign long_click[gi] = r_long;
        end
    endgenerate

endmodule

// File: tb/tb_click_key_array.sv
// Testbench for click_key_array: directed scenarios followed by random key
// activity, every cycle compared against a timing-rule reference model.
`timescale 1ns/1ps
module tb_click_key_array;
    localparam int N    = 4;
    localparam int DEB  = 3;
    localparam int LNG  = 20;
    localparam int REP  = 5;
    localparam int MAXC = 4096;
`ifdef CLICK_KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_key;
    logic [N-1:0] key_state;
    logic [N-1:0] fast_click;
    logic [N-1:0] long_click;

    click_key_array #(
        .N_KEYS(N), .IN_C_HZ(1000), .DEBOUNCE_MS(DEB), .LONG_MS(LNG),
        .REPEAT_MS(REP), .KEY_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_key(in_key), .key_state(key_state),
        .fast_click(fast_click), .long_click(long_click)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model history, indexed by clock edge number.
    logic [N-1:0] in_h [MAXC];
    logic [N-1:0] ks_h [MAXC];
    logic         rst_h[MAXC];
    int           rise_t[N];
    int           t;
    logic [N-1:0] exp_ks, exp_fast, exp_long;

    // Observation statistics for the directed scenarios.
    int           nstep;
    int           rise_cnt[N], fast_cnt[N], long_cnt[N];
    int           rise_step[N], first_long[N], last_fast[N];
    logic [N-1:0] prev_ks, fvec;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s edge %0d: observed %b expected %b", tag, t, obs, expv);
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Expected outputs after edge t, from the timing rules:
    // s_key is the raw input two edges earlier; the level flips once it has
    // differed on DEB consecutive non-reset edges; a press lasting D cycles of
    // key_state gives fast one edge after release if D<=LNG, otherwise long at
    // rise+LNG+1 (and every REP after that while held, when repeat is on).
    task automatic model_edge(input logic [N-1:0] k, input logic r);
        t++;
        rst_h[t] = !r;
        in_h[t]  = r ? k : '0;
        if (!r) begin
            ks_h[t]  = '0;
            exp_fast = '0;
            exp_long = '0;
            for (int i = 0; i < N; i++) rise_t[i] = -1;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic flip;
                int   d;
                flip = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (rst_h[t-j] || (in_h[t-j-2][i] == ks_h[t-j-1][i]) ||
                        (ks_h[t-j-1][i] != ks_h[t-1][i]))
                        flip = 1'b0;
                end
                ks_h[t][i] = flip ? ~ks_h[t-1][i] : ks_h[t-1][i];
                exp_fast[i] = !ks_h[t-1][i] && ks_h[t-2][i] && (rise_t[i] >= 0) &&
                              ((t - 1 - rise_t[i]) <= LNG);
                d = t - (rise_t[i] + 1 + LNG);
                exp_long[i] = ks_h[t-1][i] && (rise_t[i] >= 0) &&
                              ((d == 0) || (REP_ON && d > 0 && (d % REP) == 0));
                if (ks_h[t][i] && !ks_h[t-1][i]) rise_t[i] = t;
            end
        end
        exp_ks = ks_h[t];
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0; fast_cnt[i] = 0; long_cnt[i] = 0;
            rise_step[i] = -1; first_long[i] = -1; last_fast[i] = -1;
        end
        fvec = '0;
    endtask

    task automatic step(input logic [N-1:0] k, input logic r);
        in_key = k;
        rst_n  = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        check("key_state", key_state, exp_ks);
        check("fast_click", fast_click, exp_fast);
        check("long_click", long_click, exp_long);
        check("strobe_exclusive", fast_click & long_click, '0);
        nstep++;
        for (int i = 0; i < N; i++) begin
            if (key_state[i] && !prev_ks[i]) begin
                rise_cnt[i]++;
                rise_step[i] = nstep;
            end
            if (fast_click[i]) begin
                fast_cnt[i]++;
                last_fast[i] = nstep;
            end
            if (long_click[i]) begin
                long_cnt[i]++;
                if (first_long[i] < 0) first_long[i] = nstep;
            end
        end
        if (|fast_click) fvec = fast_click;
        prev_ks = key_state;
    endtask

    initial begin
        logic [N-1:0] lvl;
        int           rem[N];
        int           rel;
        logic         r;

        in_key  = '0;
        rst_n   = 1'b0;
        nstep   = 0;
        prev_ks = '0;
        for (int j = 0; j < 4; j++) begin
            in_h[j] = '0; ks_h[j] = '0; rst_h[j] = 1'b1;
        end
        t = 3;
        for (int i = 0; i < N; i++) rise_t[i] = -1;
        clear_stats();

        // T1: reset with all keys held, then held through reset release.
        for (int n = 0; n < 3; n++) begin
            step(4'hF, 1'b0);
            check("t1_reset_outputs", key_state | fast_click | long_click, 4'h0);
        end
        repeat (4) step(4'hF, 1'b1);
        check("t1_ks_before_5", key_state, 4'h0);
        step(4'hF, 1'b1);
        check("t1_ks_after_5", key_state, 4'hF);
        repeat (5) step(4'hF, 1'b1);
        repeat (15) step(4'h0, 1'b1);

        // T2: bouncing key0.
        clear_stats();
        step(4'b0001, 1'b1); step(4'b0000, 1'b1);
        step(4'b0001, 1'b1); step(4'b0000, 1'b1);
        repeat (10) step(4'b0001, 1'b1);
        rel = nstep;
        repeat (12) step(4'b0000, 1'b1);
        check_int("t2_rises", rise_cnt[0], 1);
        check_int("t2_fast_count", fast_cnt[0], 1);
        check_int("t2_fast_delay", last_fast[0] - rel, 6);
        check_int("t2_no_long", long_cnt[0], 0);

        // T3: short press on key1.
        clear_stats();
        repeat (10) step(4'b0010, 1'b1);
        repeat (20) step(4'b0000, 1'b1);
        check_int("t3_fast_count", fast_cnt[1], 1);
        check_int("t3_no_long", long_cnt[1], 0);

        // T4/T5: long press on key2.
        clear_stats();
        repeat (40) step(4'b0100, 1'b1);
        repeat (20) step(4'b0000, 1'b1);
        check_int("t4_long_delay", first_long[2] - rise_step[2], 21);
        check_int("t4_long_count", long_cnt[2], REP_ON ? 4 : 1);
        check_int("t4_no_fast", fast_cnt[2], 0);

        // T6: simultaneous presses on key0 and key3.
        clear_stats();
        repeat (8) step(4'b1001, 1'b1);
        repeat (12) step(4'b0000, 1'b1);
        check("t6_fast_vector", fvec, 4'b1001);
        check_int("t6_fast_count0", fast_cnt[0], 1);
        check_int("t6_fast_count3", fast_cnt[3], 1);

        // T6: reset while key1 is held discards the press.
        clear_stats();
        repeat (15) step(4'b0010, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        repeat (30) step(4'b0000, 1'b1);
        check_int("t6_reset_no_fast", fast_cnt[1], 0);
        check_int("t6_reset_no_long", long_cnt[1], 0);
        check("t6_reset_ks", key_state, 4'h0);

        // Random key activity: glitches, short, borderline and long holds,
        // with occasional resets.
        lvl = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    case ($urandom_range(0, 3))
                        0:       rem[i] = $urandom_range(1, 3);
                        1:       rem[i] = $urandom_range(4, 18);
                        2:       rem[i] = $urandom_range(19, 26);
                        default: rem[i] = $urandom_range(27, 50);
                    endcase
                end
                rem[i]--;
            end
            r = ($urandom_range(0, 499) != 0);
            step(lvl, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
